// File: rtl/taillight_monitor.sv
// taillight_monitor: checks the six-lamp taillight protocol, decodes the command, counts sequences and latches the first error.
// Ports: clk, rst_n (async, active low), sample (evaluate enable), lamps {Lc,Lb,La,Ra,Rb,Rc}, err_clr;
//        mode (00 idle/01 left/10 right/11 hazard), phase (0 off, 1..3 step), seq_done pulse,
//        seq_count (saturating), err (sticky), err_code (01 pattern, 10 transition, 11 stall).
module taillight_monitor #(
  parameter int SEQ_CNT_W = 8,
  parameter int STALL_MAX = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample,
  input  logic [5:0]           lamps,
  input  logic                 err_clr,
  output logic [1:0]           mode,
  output logic [1:0]           phase,
  output logic                 seq_done,
  output logic [SEQ_CNT_W-1:0] seq_count,
  output logic                 err,
  output logic [1:0]           err_code
);
  localparam logic [5:0] OFF = 6'h00, L1 = 6'h08, L2 = 6'h18, L3 = 6'h38;
  localparam logic [5:0] R1 = 6'h04, R2 = 6'h06, R3 = 6'h07, HZ = 6'h3F;
  // Wide enough to hold STALL_MAX+1, where the counter saturates.
  localparam int SW = $clog2(STALL_MAX + 2);
  logic [5:0]    prev;
  logic [SW-1:0] stall_cnt, stall_nx;
  logic          legal, same, lit, trans_ok, ill_pat, ill_tr, stall_err, any_err, done, e;
  logic [1:0]    step, code, mode_nx;
  always_comb begin
    legal     = lamps inside {OFF, L1, L2, L3, R1, R2, R3, HZ};
    same      = lamps == prev;
    lit       = lamps != OFF;
    trans_ok  = lamps == OFF
             || (prev == OFF && lamps inside {L1, R1, HZ})
             || (prev == L1 && lamps == L2) || (prev == L2 && lamps == L3)
             || (prev == R1 && lamps == R2) || (prev == R2 && lamps == R3);
    stall_nx  = (same && lit) ? ((stall_cnt == SW'(STALL_MAX + 1)) ? stall_cnt : stall_cnt + 1'b1) : '0;
    ill_pat   = !legal;
    ill_tr    = legal && !(same && lit) && !trans_ok;
    stall_err = legal && same && lit && (stall_nx > SW'(STALL_MAX));
    any_err   = ill_pat || ill_tr || stall_err;
    code      = ill_pat ? 2'b01 : ill_tr ? 2'b10 : 2'b11;
    done      = !any_err && lamps == OFF && (prev inside {L3, R3, HZ});
    step      = (lamps inside {L1, R1, HZ}) ? 2'd1 : (lamps inside {L2, R2}) ? 2'd2 :
                (lamps inside {L3, R3}) ? 2'd3 : 2'd0;
    // Mode is only chosen when leaving OFF; otherwise it is held, including through the closing OFF.
    mode_nx   = any_err ? 2'b00 :
                prev != OFF ? mode :
                lamps == L1 ? 2'b01 : lamps == R1 ? 2'b10 : lamps == HZ ? 2'b11 : 2'b00;
    e         = sample && any_err;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev      <= OFF;
      mode      <= 2'b00;
      phase     <= 2'd0;
      seq_done  <= 1'b0;
      seq_count <= '0;
      stall_cnt <= '0;
      err       <= 1'b0;
      err_code  <= 2'b00;
    end else begin
      seq_done <= sample && done;
      if (sample) begin
        prev      <= legal ? lamps : OFF;
        mode      <= mode_nx;
        phase     <= any_err ? 2'd0 : step;
        stall_cnt <= stall_nx;
        if (done && seq_count != '1) seq_count <= seq_count + 1'b1;
      end
      err      <= e || (err && !err_clr);
      // A new error recorded alongside err_clr overrides the clear.
      err_code <= (e && (!err || err_clr)) ? code : err_clr ? 2'b00 : err_code;
    end
  end
endmodule
